id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 37 +++
 rtl/forward_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, special register numbers and
// a legality helper used by the ID/EX decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic isLegalOpcode(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Opcodes whose rt field is a source operand, not a destination.
    function automatic logic readsRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding for one register read port: EX/MEM beats MEM/WB beats
// the register file, and $0 is never forwarded.
module forward_mux
    import mips_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] rf_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] operand
);

    logic w_hitExMem;
    logic w_hitMemWb;

    assign w_hitExMem = exmem_reg_write && (exmem_rd == addr) && (addr != REG_ZERO);
    // Also covers the write happening this very cycle: the RF does not bypass.
    assign w_hitMemWb = memwb_reg_write && (memwb_rd == addr) && (addr != REG_ZERO);

    always_comb begin
        operand = rf_data;
        if (w_hitExMem) begin
            operand = exmem_result;
        end else if (w_hitMemWb) begin
            operand = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID decode, load-use hazard detection and the ID/EX pipeline register of a
// 5-stage MIPS pipeline.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic [31:0] pc_plus4_in,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_illegal,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc_plus4,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_shamt
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_legal;
    logic        w_regWrite;
    logic        w_memRead;
    logic        w_memWrite;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic        w_bubble;

    logic        r_valid;
    logic        r_regWrite;
    logic        r_memRead;
    logic        r_memWrite;
    logic        r_illegal;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_imm;
    logic [31:0] r_pcPlus4;
    logic [4:0]  r_rd;
    logic [5:0]  r_opcode;
    logic [5:0]  r_funct;
    logic [4:0]  r_shamt;

    assign w_opcode = instr_in[31:26];
    assign w_funct  = instr_in[5:0];
    assign rs_addr  = instr_in[25:21];
    assign rt_addr  = instr_in[20:16];

    forward_mux u_fwdRs (
        .addr            (rs_addr),
        .rf_data         (rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .operand         (w_op1)
    );

    forward_mux u_fwdRt (
        .addr            (rt_addr),
        .rf_data         (rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .operand         (w_op2)
    );

    // Illegal opcodes fall through the default arm, so no write/memory control is raised.
    always_comb begin
        w_legal    = isLegalOpcode(w_opcode);
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_rd       = instr_in[20:16];
        w_imm      = {{16{instr_in[15]}}, instr_in[15:0]};
        case (w_opcode)
            OP_RTYPE: begin
                w_rd       = instr_in[15:11];
                w_regWrite = (w_funct != FUNCT_JR);
            end
            OP_JAL: begin
                w_rd       = REG_RA;
                w_regWrite = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI: w_regWrite = 1'b1;
            OP_ANDI, OP_ORI: begin
                w_regWrite = 1'b1;
                w_imm      = {16'h0000, instr_in[15:0]};
            end
            OP_LW: begin
                w_regWrite = 1'b1;
                w_memRead  = 1'b1;
            end
            OP_SW:   w_memWrite = 1'b1;
            default: ;
        endcase
    end

    assign stall = r_valid && r_memRead && (r_rd != REG_ZERO) && instr_valid && !flush &&
                   ((r_rd == rs_addr) || ((r_rd == rt_addr) && readsRt(w_opcode)));

    assign w_bubble = stall || flush || !instr_valid;

    // Data fields load every cycle; a bubble only clears the valid and control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_imm      <= '0;
            r_pcPlus4  <= '0;
            r_rd       <= '0;
            r_opcode   <= '0;
            r_funct    <= '0;
            r_shamt    <= '0;
        end else begin
            r_valid    <= !w_bubble;
            r_regWrite <= !w_bubble && w_regWrite;
            r_memRead  <= !w_bubble && w_memRead;
            r_memWrite <= !w_bubble && w_memWrite;
            r_illegal  <= !w_bubble && !w_legal;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_imm      <= w_imm;
            r_pcPlus4  <= pc_plus4_in;
            r_rd       <= w_rd;
            r_opcode   <= w_opcode;
            r_funct    <= w_funct;
            r_shamt    <= instr_in[10:6];
        end
    end

    assign ex_valid     = r_valid;
    assign ex_reg_write = r_regWrite;
    assign ex_mem_read  = r_memRead;
    assign ex_mem_write = r_memWrite;
    assign ex_illegal   = r_illegal;
    assign ex_op1       = r_op1;
    assign ex_op2       = r_op2;
    assign ex_imm       = r_imm;
    assign ex_pc_plus4  = r_pcPlus4;
    assign ex_rd        = r_rd;
    assign ex_opcode    = r_opcode;
    assign ex_funct     = r_funct;
    assign ex_shamt     = r_shamt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding, decode fields,
// load-use stall, flush, illegal opcodes and asynchronous reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic [31:0] pc_plus4_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt;

    int testsRun;
    int testsFailed;

    localparam logic [31:0] I_ADD_3_1_1 = 32'h0021_1820;
    localparam logic [31:0] I_ADD_3_2_0 = 32'h0040_1820;
    localparam logic [31:0] I_ADD_3_0_0 = 32'h0000_1820;
    localparam logic [31:0] I_LW_4      = 32'h8C04_0000;
    localparam logic [31:0] I_ADD_5_4_0 = 32'h0080_2820;
    localparam logic [31:0] I_ADD_5_0_4 = 32'h0004_2820;
    localparam logic [31:0] I_ADDI_4    = 32'h2004_0001;
    localparam logic [31:0] I_JAL       = 32'h0C00_0010;
    localparam logic [31:0] I_ORI_8000  = 32'h3402_8000;
    localparam logic [31:0] I_ADDI_8000 = 32'h2002_8000;
    localparam logic [31:0] I_SW_4      = 32'hAC04_0000;
    localparam logic [31:0] I_JR_31     = 32'h03E0_0008;
    localparam logic [31:0] I_ILLEGAL   = 32'hFC00_0000;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .instr_in        (instr_in),
        .instr_valid     (instr_valid),
        .pc_plus4_in     (pc_plus4_in),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .flush           (flush),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_illegal      (ex_illegal),
        .ex_op1          (ex_op1),
        .ex_op2          (ex_op2),
        .ex_imm          (ex_imm),
        .ex_pc_plus4     (ex_pc_plus4),
        .ex_rd           (ex_rd),
        .ex_opcode       (ex_opcode),
        .ex_funct        (ex_funct),
        .ex_shamt        (ex_shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic fl);
        instr_in    = instr;
        instr_valid = valid;
        flush       = fl;
        pc_plus4_in = pc_plus4_in + 32'd4;
        #1;
    endtask

    task automatic clearForwarding();
        exmem_reg_write = 1'b0;
        exmem_rd        = 5'd0;
        exmem_result    = 32'h0;
        memwb_reg_write = 1'b0;
        memwb_rd        = 5'd0;
        memwb_data      = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        instr_in    = 32'h0;
        instr_valid = 1'b0;
        pc_plus4_in = 32'h0000_1000;
        rs_data     = 32'h0;
        rt_data     = 32'h0;
        flush       = 1'b0;
        clearForwarding();
        #1;
        checkOutput("reset_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("reset_op1", ex_op1, 32'h0);
        checkOutput("reset_stall", {31'b0, stall}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // First edge after reset captures a real instruction with EX/MEM forwarding.
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd5;
        applyStimulus(I_ADD_3_1_1, 1'b1, 1'b0);
        checkOutput("rs_addr_comb", {27'b0, rs_addr}, 32'd1);
        tick();
        checkOutput("fwd_exmem_op1", ex_op1, 32'd5);
        checkOutput("fwd_exmem_op2", ex_op2, 32'd5);
        checkOutput("add_rd", {27'b0, ex_rd}, 32'd3);
        checkOutput("add_regwrite", {31'b0, ex_reg_write}, 32'd1);
        checkOutput("add_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("add_funct", {26'b0, ex_funct}, 32'h20);

        // EX/MEM wins over MEM/WB; MEM/WB used alone; $0 never forwarded; plain RF read.
        exmem_reg_write = 1'b1; exmem_rd = 5'd2; exmem_result = 32'd7;
        memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_data = 32'd9;
        rs_data = 32'h0000_1111;
        applyStimulus(I_ADD_3_2_0, 1'b1, 1'b0);
        tick();
        checkOutput("fwd_priority", ex_op1, 32'd7);
        exmem_reg_write = 1'b0;
        applyStimulus(I_ADD_3_2_0, 1'b1, 1'b0);
        tick();
        checkOutput("fwd_memwb", ex_op1, 32'd9);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_data = 32'h66;
        rs_data = 32'h0;
        applyStimulus(I_ADD_3_0_0, 1'b1, 1'b0);
        tick();
        checkOutput("fwd_zero_reg", ex_op1, 32'h0);
        clearForwarding();
        rs_data = 32'h0000_1234;
        applyStimulus(I_ADD_3_2_0, 1'b1, 1'b0);
        tick();
        checkOutput("rf_read", ex_op1, 32'h0000_1234);
        rs_data = 32'h0;

        // Decode fields.
        applyStimulus(I_JAL, 1'b1, 1'b0);
        tick();
        checkOutput("jal_rd", {27'b0, ex_rd}, 32'd31);
        checkOutput("jal_regwrite", {31'b0, ex_reg_write}, 32'd1);
        applyStimulus(I_ORI_8000, 1'b1, 1'b0);
        tick();
        checkOutput("ori_imm", ex_imm, 32'h0000_8000);
        checkOutput("ori_rd", {27'b0, ex_rd}, 32'd2);
        applyStimulus(I_ADDI_8000, 1'b1, 1'b0);
        tick();
        checkOutput("addi_imm", ex_imm, 32'hFFFF_8000);
        applyStimulus(I_SW_4, 1'b1, 1'b0);
        tick();
        checkOutput("sw_memwrite", {31'b0, ex_mem_write}, 32'd1);
        checkOutput("sw_regwrite", {31'b0, ex_reg_write}, 32'd0);
        applyStimulus(I_JR_31, 1'b1, 1'b0);
        tick();
        checkOutput("jr_regwrite", {31'b0, ex_reg_write}, 32'd0);
        applyStimulus(I_ILLEGAL, 1'b1, 1'b0);
        tick();
        checkOutput("illegal_flag", {31'b0, ex_illegal}, 32'd1);
        checkOutput("illegal_regwrite", {31'b0, ex_reg_write}, 32'd0);
        applyStimulus(I_ADD_3_1_1, 1'b0, 1'b0);
        tick();
        checkOutput("invalid_bubble", {31'b0, ex_valid}, 32'd0);
        checkOutput("invalid_regwrite", {31'b0, ex_reg_write}, 32'd0);

        // Load-use: one stall cycle, one bubble, then MEM/WB supplies the load value.
        applyStimulus(I_LW_4, 1'b1, 1'b0);
        tick();
        checkOutput("lw_memread", {31'b0, ex_mem_read}, 32'd1);
        checkOutput("lw_rd", {27'b0, ex_rd}, 32'd4);
        applyStimulus(I_ADD_5_4_0, 1'b1, 1'b0);
        checkOutput("loaduse_stall", {31'b0, stall}, 32'd1);
        tick();
        checkOutput("loaduse_bubble", {31'b0, ex_valid}, 32'd0);
        checkOutput("bubble_regwrite", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("stall_released", {31'b0, stall}, 32'd0);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_data = 32'hDEAD_BEEF;
        #1;
        tick();
        checkOutput("loaduse_fwd", ex_op1, 32'hDEAD_BEEF);
        checkOutput("loaduse_valid", {31'b0, ex_valid}, 32'd1);
        clearForwarding();

        // rt hazard only for opcodes that read rt.
        applyStimulus(I_LW_4, 1'b1, 1'b0);
        tick();
        applyStimulus(I_ADD_5_0_4, 1'b1, 1'b0);
        checkOutput("rt_hazard_stall", {31'b0, stall}, 32'd1);
        applyStimulus(I_ADDI_4, 1'b1, 1'b0);
        checkOutput("addi_rt_nostall", {31'b0, stall}, 32'd0);

        // Flush overrides the hazard and loads a bubble.
        applyStimulus(I_ADD_5_4_0, 1'b1, 1'b1);
        checkOutput("flush_stall", {31'b0, stall}, 32'd0);
        tick();
        checkOutput("flush_bubble", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_regwrite", {31'b0, ex_reg_write}, 32'd0);

        // Asynchronous reset between edges while EX holds lw $4.
        applyStimulus(I_LW_4, 1'b1, 1'b0);
        tick();
        applyStimulus(I_ADD_5_4_0, 1'b1, 1'b0);
        checkOutput("prereset_stall", {31'b0, stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_memread", {31'b0, ex_mem_read}, 32'd0);
        checkOutput("async_rst_rd", {27'b0, ex_rd}, 32'd0);
        checkOutput("async_rst_regwrite", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("async_rst_pc", ex_pc_plus4, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(I_ADD_3_1_1, 1'b1, 1'b0);
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd42;
        #1;
        tick();
        checkOutput("post_reset_capture", ex_op1, 32'd42);
        checkOutput("post_reset_valid", {31'b0, ex_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
